// File: rtl/stream_router_pkg.sv
// Shared width helpers and constants for the stream router and its per-channel queues.
package stream_router_pkg;

    localparam int DROP_W = 16;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    function automatic int addr_width(input int num_out);
        return $clog2(num_out);
    endfunction

    // Occupancy needs one extra bit so that a completely full queue (DEPTH) is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/stream_router_fifo.sv
// router_fifo: one output channel's queue; pushes are refused whenever full, even if the head pops.
module router_fifo
    import stream_router_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int PTR_W = ptr_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  push;
    logic                  pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && !full;
    assign pop       = out_ready && out_valid;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/stream_router.sv
// stream_router: routes one input stream to NUM_OUT queued channels by address, or to all of them on broadcast.
module stream_router
    import stream_router_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_OUT    = 4,
    parameter int DEPTH      = 2,
    localparam int ADDR_W    = addr_width(NUM_OUT)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         din,
    input  logic                          din_valid,
    output logic                          din_ready,
    input  logic [ADDR_W-1:0]             addr,
    input  logic                          bcast,
    output logic [NUM_OUT*DATA_WIDTH-1:0] dout,
    output logic [NUM_OUT-1:0]            dout_valid,
    input  logic [NUM_OUT-1:0]            dout_ready,
    output logic [DROP_W-1:0]             drop_cnt
);

    logic [NUM_OUT-1:0] full;
    logic [NUM_OUT-1:0] push;
    logic               accept;

    // Ready looks only at registered occupancy, so consumer ready never reaches din_ready.
    assign din_ready = !reset && (bcast ? !(|full) : !full[addr]);
    assign accept    = din_valid && din_ready;

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_chan
        assign push[i] = accept && (bcast || (addr == ADDR_W'(i)));

        router_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .in_data   (din),
            .in_valid  (push[i]),
            .full      (full[i]),
            .out_data  (dout[i*DATA_WIDTH +: DATA_WIDTH]),
            .out_valid (dout_valid[i]),
            .out_ready (dout_ready[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (din_valid && !din_ready && (drop_cnt != DROP_MAX)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_router.sv
// Randomised and directed bench for stream_router against a queue-based reference model.
module tb_stream_router;

    localparam int DW    = 32;
    localparam int NO    = 4;
    localparam int DEPTH = 2;
    localparam int AW    = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DW-1:0]     din = '0;
    logic              din_valid = 1'b0;
    logic              din_ready;
    logic [AW-1:0]     addr = '0;
    logic              bcast = 1'b0;
    logic [NO*DW-1:0]  dout;
    logic [NO-1:0]     dout_valid;
    logic [NO-1:0]     dout_ready = '0;
    logic [15:0]       drop_cnt;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0]    mq [NO][$];
    int               exp_drop = 0;
    logic             exp_ready;
    logic             obs_ready;
    logic [NO*DW-1:0] exp_dout;
    logic [NO-1:0]    exp_valid;

    stream_router #(.DATA_WIDTH(DW), .NUM_OUT(NO), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .addr       (addr),
        .bcast      (bcast),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    // One clock cycle: drive inputs, sample ready before the edge, update the model, settle on the falling edge.
    task automatic step(input logic rst, input logic v, input logic b, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [NO-1:0] rdy);
        logic any_full;
        reset = rst; din_valid = v; bcast = b; addr = a; din = d; dout_ready = rdy;
        #1;
        obs_ready = din_ready;
        any_full = 1'b0;
        for (int i = 0; i < NO; i++) if (mq[i].size() == DEPTH) any_full = 1'b1;
        if (rst) exp_ready = 1'b0;
        else     exp_ready = b ? !any_full : (mq[int'(a)].size() < DEPTH);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NO; i++) mq[i].delete();
            exp_drop = 0;
        end else begin
            for (int i = 0; i < NO; i++)
                if (rdy[i] && mq[i].size() > 0) void'(mq[i].pop_front());
            if (v && exp_ready)
                for (int i = 0; i < NO; i++)
                    if (b || int'(a) == i) mq[i].push_back(d);
            if (v && !exp_ready && exp_drop < 65535) exp_drop++;
        end
        @(negedge clk);
        for (int i = 0; i < NO; i++) begin
            exp_valid[i] = (mq[i].size() > 0);
            exp_dout[i*DW +: DW] = (mq[i].size() > 0) ? mq[i][0] : '0;
        end
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b0, 2'd1, 32'h1111_2222, 4'hF);
        checks++;
        if (obs_ready !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_ready actual=%b required=0", obs_ready);
        end
        step(1'b1, 1'b1, 1'b1, 2'd0, 32'h3333_4444, 4'hF);
        checks++;
        if (dout_valid !== 4'b0000 || dout !== '0 || drop_cnt !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_state actual valid=%b dout=%h drop=%0d required 0/0/0",
                     dout_valid, dout, drop_cnt);
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, (k == 4), AW'(k), 32'h0, 4'h0);
            checks++;
            if (obs_ready !== 1'b1) begin
                failures++; $display("[TB] FAIL post_reset_ready pattern=%0d actual=%b required=1", k, obs_ready);
            end
        end
    endtask

    task automatic test_unicast();
        step(1'b0, 1'b1, 1'b0, 2'd2, 32'hA5A5_0001, 4'h0);
        checks++;
        if (dout_valid !== 4'b0100) begin
            failures++; $display("[TB] FAIL unicast_valid actual=%b required=0100", dout_valid);
        end
        checks++;
        if (dout !== {32'h0, 32'hA5A5_0001, 64'h0}) begin
            failures++; $display("[TB] FAIL unicast_dout actual=%h required=%h", dout, {32'h0, 32'hA5A5_0001, 64'h0});
        end
        step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 4'hF);
        checks++;
        if (dout_valid !== 4'b0000) begin
            failures++; $display("[TB] FAIL unicast_drain actual=%b required=0000", dout_valid);
        end
    endtask

    task automatic test_fill();
        logic [DW-1:0] words [3];
        words[0] = 32'h0000_1001; words[1] = 32'h0000_1002; words[2] = 32'h0000_1003;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b0, 2'd1, words[k], 4'h0);
            checks++;
            if (obs_ready !== (k < 2)) begin
                failures++; $display("[TB] FAIL fill_ready word=%0d actual=%b required=%b", k, obs_ready, (k < 2));
            end
        end
        checks++;
        if (drop_cnt !== 16'd1) begin
            failures++; $display("[TB] FAIL fill_drop actual=%0d required=1", drop_cnt);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dout_valid[1] !== 1'b1 || dout[DW +: DW] !== words[k]) begin
                failures++; $display("[TB] FAIL fill_order word=%0d actual=%h required=%h", k, dout[DW +: DW], words[k]);
            end
            step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 4'b0010);
        end
        checks++;
        if (dout_valid !== 4'b0000) begin
            failures++; $display("[TB] FAIL fill_empty actual=%b required=0000", dout_valid);
        end
    endtask

    task automatic test_broadcast();
        step(1'b0, 1'b1, 1'b1, 2'd2, 32'hDEAD_BEEF, 4'h0);
        checks++;
        if (dout_valid !== 4'b1111 || dout !== {4{32'hDEAD_BEEF}}) begin
            failures++; $display("[TB] FAIL bcast_all actual valid=%b dout=%h required 1111/%h",
                                 dout_valid, dout, {4{32'hDEAD_BEEF}});
        end
        step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 4'hF);
        step(1'b0, 1'b1, 1'b0, 2'd3, 32'h0000_3001, 4'h0);
        step(1'b0, 1'b1, 1'b0, 2'd3, 32'h0000_3002, 4'h0);
        step(1'b0, 1'b1, 1'b1, 2'd0, 32'h1234_5678, 4'h0);
        checks++;
        if (obs_ready !== 1'b0) begin
            failures++; $display("[TB] FAIL bcast_stall_ready actual=%b required=0", obs_ready);
        end
        checks++;
        if (dout_valid !== 4'b1000 || dout !== {32'h0000_3001, 96'h0}) begin
            failures++; $display("[TB] FAIL bcast_stall_state actual valid=%b dout=%h required 1000/%h",
                                 dout_valid, dout, {32'h0000_3001, 96'h0});
        end
        step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 4'hF);
        step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 4'hF);
    endtask

    task automatic test_full_pop();
        step(1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_5001, 4'h0);
        step(1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_5002, 4'h0);
        step(1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_5003, 4'b0001);
        checks++;
        if (obs_ready !== 1'b0) begin
            failures++; $display("[TB] FAIL fullpop_ready actual=%b required=0", obs_ready);
        end
        checks++;
        if (dout_valid !== 4'b0001 || dout[DW-1:0] !== 32'h0000_5002) begin
            failures++; $display("[TB] FAIL fullpop_head actual valid=%b head=%h required 0001/00005002",
                                 dout_valid, dout[DW-1:0]);
        end
        step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 4'b0001);
        checks++;
        if (dout_valid !== 4'b0000 || drop_cnt !== exp_drop[15:0]) begin
            failures++; $display("[TB] FAIL fullpop_after actual valid=%b drop=%0d required 0000/%0d",
                                 dout_valid, drop_cnt, exp_drop);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step(1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), AW'($urandom_range(0, NO-1)),
                 $urandom, NO'($urandom & $urandom));
            checks++;
            if (obs_ready !== exp_ready || dout_valid !== exp_valid || dout !== exp_dout
                || drop_cnt !== exp_drop[15:0]) begin
                failures++;
                $display("[TB] FAIL random cyc=%0d actual rdy=%b v=%b d=%h drop=%0d required rdy=%b v=%b d=%h drop=%0d",
                         n, obs_ready, dout_valid, dout, drop_cnt, exp_ready, exp_valid, exp_dout, exp_drop);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 4'hF);
        step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 4'hF);
        step(1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_7001, 4'h0);
        step(1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_7002, 4'h0);
        checks++;
        if (dout_valid !== 4'b0101) begin
            failures++; $display("[TB] FAIL midreset_pre actual=%b required=0101", dout_valid);
        end
        step(1'b1, 1'b1, 1'b1, 2'd0, 32'h0000_7003, 4'h0);
        checks++;
        if (obs_ready !== 1'b0 || dout_valid !== 4'b0000 || dout !== '0 || drop_cnt !== 16'd0) begin
            failures++; $display("[TB] FAIL midreset_clear actual rdy=%b valid=%b drop=%0d required 0/0000/0",
                                 obs_ready, dout_valid, drop_cnt);
        end
        step(1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 4'h0);
        checks++;
        if (obs_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL midreset_ready actual=%b required=1", obs_ready);
        end
    endtask

    task automatic test_saturation();
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
        step(1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_9001, 4'h0);
        step(1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_9002, 4'h0);
        for (int n = 1; n <= 65540; n++) begin
            step(1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_9999, 4'h0);
            if (n == 65534) begin
                checks++;
                if (drop_cnt !== 16'hFFFE) begin
                    failures++; $display("[TB] FAIL sat_before actual=%h required=fffe", drop_cnt);
                end
            end
        end
        checks++;
        if (drop_cnt !== 16'hFFFF || exp_drop != 65535) begin
            failures++; $display("[TB] FAIL sat_hold actual=%h required=ffff", drop_cnt);
        end
        checks++;
        if (dout_valid !== 4'b0001 || dout[DW-1:0] !== 32'h0000_9001) begin
            failures++; $display("[TB] FAIL sat_head actual valid=%b head=%h required 0001/00009001",
                                 dout_valid, dout[DW-1:0]);
        end
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_fill();
        test_broadcast();
        test_full_pop();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
